pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter and feeds the decode stage. Issues 16-bit instruction
//  fetches (PC step 2) to instruction memory over a req/ack handshake and accepts
//  branch redirects carrying the target computed by the branch adder
//  (pc_plus_two + (imm<<1)). Single outstanding fetch; stale data is discarded.
// PARAMETERS
//  PC_WIDTH     16       PC / address width in bits
//  INSTR_WIDTH  16       instruction word width
//  RESET_PC     16'h0000 first fetch address after reset (bit0 must be 0)
// PORTS
//  clk              in   1            single clock, rising edge
//  rst_n            in   1            asynchronous, active-low reset
//  redirect_valid   in   1            branch taken this cycle; load redirect_target
//  redirect_target  in   PC_WIDTH     jump address from branch adder
//  stall            in   1            decode cannot accept; hold instr outputs
//  imem_req         out  1            fetch request, held until imem_ack
//  imem_addr        out  PC_WIDTH     fetch address, stable while imem_req=1
//  imem_ack         in   1            read data valid this cycle
//  imem_rdata       in   INSTR_WIDTH  instruction word
//  instr_valid      out  1            instr/instr_pc/pc_plus_two valid
//  instr            out  INSTR_WIDTH  fetched instruction
//  instr_pc         out  PC_WIDTH     address of instr
//  pc_plus_two      out  PC_WIDTH     instr_pc + 2, to branch adder
//  misalign_err     out  1            1-cycle pulse: redirect_target bit0 was 1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   instr_valid=0, instr=0, instr_pc=0, pc_plus_two=0, misalign_err=0.
//  States: BOOT, FETCH, DRAIN, HOLD. All outputs registered.
//  BOOT: one cycle after reset release -> FETCH, imem_req=1, imem_addr=pc.
//  FETCH: imem_req=1. On imem_ack with no redirect: capture rdata into instr,
//   instr_pc=pc, pc_plus_two=pc+2, instr_valid=1 next cycle; pc<=pc+2.
//   If stall=1 in the ack cycle -> HOLD (imem_req=0); else stay FETCH, next
//   request at pc+2 issued the following cycle (fetch latency = 1 cycle after ack).
//  Fetch throughput: one instruction per 2 cycles minimum (req, ack/capture).
//  HOLD: imem_req=0; instr_valid/instr/instr_pc/pc_plus_two frozen while stall=1;
//   stall=0 -> FETCH at current pc.
//  instr_valid drops to 0 in any cycle with no newly accepted instruction and
//   no stall hold.
//  Redirect (any state except BOOT; highest priority over ack and stall):
//   pc<=redirect_target with bit0 forced 0; instr_valid<=0 next cycle.
//   In FETCH with imem_ack=1 same cycle: ack data discarded; next request at target.
//   In FETCH with imem_ack=0: request outstanding, imem_addr must not change ->
//    DRAIN; keep imem_req=1 on old addr, discard data on ack, then FETCH at target.
//   In DRAIN: latest redirect wins; stay DRAIN until ack.
//   In HOLD: -> FETCH at target regardless of stall.
//   Redirect in BOOT: pc updated; BOOT still completes in one cycle.
//   misalign_err pulses 1 cycle when redirect_valid=1 and target[0]=1.
//  Arithmetic: pc+2 is modulo 2^PC_WIDTH; 16'hFFFE + 2 wraps to 16'h0000, no flag.
//  pc bit0 is always 0.
//  rst_n low mid-transaction: immediate return to reset values; an ack arriving
//   while in reset or in the BOOT cycle is ignored.
// TESTING
//  1 Reset release, imem_ack 1 cycle after each req, rdata=16'hA000+addr -> fetches at
//    0000,0002,0004; instr_valid pulses with instr_pc/pc_plus_two = 0000/0002 etc.
//  2 Redirect to 16'h0040 same cycle as ack of 0006 -> 0006 data dropped, next
//    imem_addr=0040, no instr_valid for 0006.
//  3 Redirect to 16'h0100 while 0008 pending (ack 3 cycles late) -> imem_addr stays
//    0008 until ack, data discarded, then imem_addr=0100.
//  4 stall=1 for 5 cycles after ack of 0010 -> imem_req=0, instr held stable;
//    stall=0 -> next fetch 0012; redirect during stall -> instr_valid=0, fetch target.
//  5 RESET_PC=16'hFFFE -> second fetch address 0000; redirect_target=16'h0031 ->
//    misalign_err pulse, fetch at 0030.
//  6 rst_n asserted while req pending -> req=0 immediately; after release, fetch RESET_PC.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the program counter and feeds decode. Fetches 16-bit instructions
//   (PC step 2) over a single-outstanding req/ack handshake and accepts branch
//   redirects. Data from a fetch that was overtaken by a redirect is dropped.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   redirect_valid/
//   redirect_target     branch taken this cycle, jump address (bit0 ignored)
//   stall               decode cannot accept; hold the instruction outputs
//   imem_req/imem_addr  fetch request, address stable while req is high
//   imem_ack/imem_rdata read data valid this cycle
//   instr_valid, instr,
//   instr_pc,
//   pc_plus_two         fetched instruction bundle to decode
//   misalign_err        1-cycle pulse when a redirect target had bit0 set
//
// All outputs come straight from flops.

module pc_fetch_sequencer #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  input  logic                   stall,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic [PC_WIDTH-1:0]    pc_plus_two,
  output logic                   misalign_err
);

  // BOOT : single cycle after reset, raises the first request
  // FETCH: request outstanding, data wanted
  // DRAIN: request outstanding but stale (redirect arrived before its ack)
  // HOLD : instruction parked at decode, no request in flight
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_plus_two;
  } dec_t;

  localparam logic [PC_WIDTH-1:0] BOOT_PC = {RESET_PC[PC_WIDTH-1:1], 1'b0};
  localparam logic [PC_WIDTH-1:0] STEP    = PC_WIDTH'(2);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                req_q, req_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                vld_q, vld_d;
  dec_t                dec_q, dec_d;
  logic                mis_q, mis_d;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] tgt;

  // pc stays even: increments are by 2 and targets get bit0 cleared
  assign pc_inc = pc_q + STEP;
  assign tgt    = {redirect_target[PC_WIDTH-1:1], 1'b0};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    // Without a fresh instruction the current one survives only while
    // decode is stalled on it.
    vld_d   = vld_q & stall;
    dec_d   = dec_q;
    mis_d   = redirect_valid & redirect_target[0];

    unique case (state_q)
      BOOT: begin
        // Any ack here belongs to nothing we issued; ignore it.
        state_d = FETCH;
        req_d   = 1'b1;
        vld_d   = 1'b0;
        if (redirect_valid) begin
          pc_d   = tgt;
          addr_d = tgt;
        end else begin
          addr_d = pc_q;
        end
      end

      FETCH: begin
        if (redirect_valid) begin
          pc_d  = tgt;
          vld_d = 1'b0;
          if (imem_ack) begin
            addr_d = tgt;         // data dropped, request target next
          end else begin
            state_d = DRAIN;      // address must hold until the ack
          end
        end else if (imem_ack) begin
          dec_d.instr       = imem_rdata;
          dec_d.pc          = pc_q;
          dec_d.pc_plus_two = pc_inc;
          vld_d             = 1'b1;
          pc_d              = pc_inc;
          if (stall) begin
            state_d = HOLD;
            req_d   = 1'b0;
          end else begin
            addr_d = pc_inc;
          end
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          pc_d  = tgt;            // latest redirect wins
          vld_d = 1'b0;
        end
        if (imem_ack) begin
          state_d = FETCH;
          addr_d  = redirect_valid ? tgt : pc_q;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          vld_d   = 1'b0;
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = tgt;
        end else if (!stall) begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= BOOT_PC;
      req_q   <= 1'b0;
      addr_q  <= BOOT_PC;
      vld_q   <= 1'b0;
      dec_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      dec_q   <= dec_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign instr_valid  = vld_q;
  assign instr        = dec_q.instr;
  assign instr_pc     = dec_q.pc;
  assign pc_plus_two  = dec_q.pc_plus_two;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer. Two instances run in lockstep on shared
// redirect/stall/reset: one booting at 0000, one at FFFE (wrap case).
module tb_pc_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect_valid, stall;
  logic [15:0] redirect_target;
  logic        imem_req [2];
  logic        imem_ack [2];
  logic        instr_valid [2];
  logic        misalign_err [2];
  logic [15:0] imem_addr [2];
  logic [15:0] imem_rdata [2];
  logic [15:0] instr [2];
  logic [15:0] instr_pc [2];
  logic [15:0] pc_plus_two [2];

  pc_fetch_sequencer #(.PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall),
    .imem_req(imem_req[0]), .imem_addr(imem_addr[0]), .imem_ack(imem_ack[0]),
    .imem_rdata(imem_rdata[0]), .instr_valid(instr_valid[0]), .instr(instr[0]),
    .instr_pc(instr_pc[0]), .pc_plus_two(pc_plus_two[0]), .misalign_err(misalign_err[0]));

  pc_fetch_sequencer #(.PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'hFFFE)) dut1 (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall),
    .imem_req(imem_req[1]), .imem_addr(imem_addr[1]), .imem_ack(imem_ack[1]),
    .imem_rdata(imem_rdata[1]), .instr_valid(instr_valid[1]), .instr(instr[1]),
    .instr_pc(instr_pc[1]), .pc_plus_two(pc_plus_two[1]), .misalign_err(misalign_err[1]));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A request is either absent, live, or stale (overtaken by a redirect).
  logic [15:0] rst_pc [2];
  bit          m_boot [2];
  logic [15:0] m_pc [2];
  bit          m_req [2];
  bit          m_stale [2];
  logic [15:0] m_addr [2];
  bit          m_valid [2];
  logic [15:0] m_instr [2];
  logic [15:0] m_ipc [2];
  logic [15:0] m_ppt [2];
  bit          m_mis [2];

  task automatic model_reset(input int d);
    m_boot[d] = 0; m_pc[d] = rst_pc[d]; m_req[d] = 0; m_stale[d] = 0;
    m_addr[d] = rst_pc[d]; m_valid[d] = 0; m_instr[d] = 0; m_ipc[d] = 0;
    m_ppt[d] = 0; m_mis[d] = 0;
  endtask

  task automatic model_step(input int d);
    logic [15:0] t;
    t = redirect_target & 16'hFFFE;
    m_mis[d] = redirect_valid && redirect_target[0];
    if (!m_boot[d]) begin
      m_boot[d] = 1;
      if (redirect_valid) m_pc[d] = t;
      m_req[d] = 1; m_addr[d] = m_pc[d]; m_valid[d] = 0;
    end else if (redirect_valid) begin
      m_pc[d] = t; m_valid[d] = 0;
      if (m_req[d] && !imem_ack[d]) m_stale[d] = 1;
      else begin m_req[d] = 1; m_addr[d] = t; m_stale[d] = 0; end
    end else if (m_req[d] && imem_ack[d] && m_stale[d]) begin
      m_stale[d] = 0; m_addr[d] = m_pc[d]; m_valid[d] = m_valid[d] && stall;
    end else if (m_req[d] && imem_ack[d]) begin
      m_instr[d] = imem_rdata[d]; m_ipc[d] = m_pc[d]; m_ppt[d] = m_pc[d] + 16'd2;
      m_valid[d] = 1; m_pc[d] = m_pc[d] + 16'd2;
      if (stall) m_req[d] = 0; else m_addr[d] = m_pc[d];
    end else begin
      m_valid[d] = m_valid[d] && stall;
      if (!m_req[d] && !stall) begin m_req[d] = 1; m_addr[d] = m_pc[d]; end
    end
  endtask

  task automatic compare(input int d);
    chk($sformatf("d%0d imem_req", d), imem_req[d], m_req[d]);
    if (m_req[d]) chk($sformatf("d%0d imem_addr", d), imem_addr[d], m_addr[d]);
    chk($sformatf("d%0d instr_valid", d), instr_valid[d], m_valid[d]);
    if (m_valid[d]) begin
      chk($sformatf("d%0d instr", d), instr[d], m_instr[d]);
      chk($sformatf("d%0d instr_pc", d), instr_pc[d], m_ipc[d]);
      chk($sformatf("d%0d pc_plus_two", d), pc_plus_two[d], m_ppt[d]);
    end
    chk($sformatf("d%0d misalign_err", d), misalign_err[d], m_mis[d]);
  endtask

  // ---------------- instruction memory ----------------
  // Acks a request `lat` cycles after it first appears; rdata = A000+addr.
  int          lat = 1;
  bit          force_ack = 0;
  int          age [2];
  bit          prev_req [2];
  bit          prev_ack [2];
  logic [15:0] log0 [$];
  logic [15:0] log1 [$];

  task automatic mem_update();
    for (int d = 0; d < 2; d++) begin
      if (imem_req[d]) begin
        if (!prev_req[d] || prev_ack[d]) begin
          age[d] = 0;
          if (d == 0) log0.push_back(imem_addr[d]); else log1.push_back(imem_addr[d]);
        end else age[d]++;
      end else age[d] = 0;
      prev_req[d]   = imem_req[d];
      imem_ack[d]   = force_ack || (imem_req[d] && age[d] >= lat);
      imem_rdata[d] = 16'hA000 + imem_addr[d];
      prev_ack[d]   = imem_ack[d];
    end
  endtask

  // One clock: advance model on current inputs, clock, check, respond.
  task automatic cycle();
    for (int d = 0; d < 2; d++) if (rst_n) model_step(d);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      compare(d);
    end
    mem_update();
  endtask

  task automatic run_until_ack(input logic [15:0] a, input int max);
    int n;
    n = 0;
    while (!(imem_ack[0] && imem_req[0] && imem_addr[0] == a) && n < max) begin
      cycle();
      n++;
    end
    chk($sformatf("ack of %h within %0d cycles", a, max),
        imem_ack[0] && imem_req[0] && imem_addr[0] == a, 1'b1);
  endtask

  logic [15:0] exp_log [3];

  initial begin
    rst_pc[0] = 16'h0000; rst_pc[1] = 16'hFFFE;
    rst_n = 0; redirect_valid = 0; redirect_target = 0; stall = 0;
    for (int d = 0; d < 2; d++) begin
      imem_ack[d] = 0; imem_rdata[d] = 0; age[d] = 0;
      prev_req[d] = 0; prev_ack[d] = 0; model_reset(d);
    end
    repeat (2) cycle();
    chk("reset req", imem_req[0], 1'b0);
    chk("reset addr d0", imem_addr[0], 16'h0000);
    chk("reset addr d1", imem_addr[1], 16'hFFFE);
    chk("reset valid", instr_valid[0], 1'b0);
    chk("reset instr", instr[0], 16'h0000);
    chk("reset instr_pc", instr_pc[0], 16'h0000);
    chk("reset pc_plus_two", pc_plus_two[0], 16'h0000);
    chk("reset misalign", misalign_err[0], 1'b0);

    // 1: sequential fetch
    #2 rst_n = 1;
    cycle();
    chk("t1 first req", imem_req[0], 1'b1);
    chk("t1 first addr d0", imem_addr[0], 16'h0000);
    chk("t1 first addr d1", imem_addr[1], 16'hFFFE);
    run_until_ack(16'h0000, 10);
    cycle();
    chk("t1 valid", instr_valid[0], 1'b1);
    chk("t1 instr", instr[0], 16'hA000);
    chk("t1 instr_pc", instr_pc[0], 16'h0000);
    chk("t1 pc_plus_two", pc_plus_two[0], 16'h0002);
    chk("t1 d1 instr", instr[1], 16'h9FFE);
    chk("t1 d1 instr_pc", instr_pc[1], 16'hFFFE);
    chk("t1 d1 pc_plus_two wrap", pc_plus_two[1], 16'h0000);
    run_until_ack(16'h0002, 10);
    run_until_ack(16'h0004, 10);
    exp_log = '{16'h0000, 16'h0002, 16'h0004};
    chk("t1 fetch count", log0.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t1 fetch %0d", i), log0[i], exp_log[i]);
    chk("t5 d1 second fetch wraps", log1[1], 16'h0000);

    // 2: redirect on the ack cycle
    run_until_ack(16'h0006, 10);
    redirect_valid = 1; redirect_target = 16'h0040;
    cycle();
    redirect_valid = 0;
    chk("t2 addr", imem_addr[0], 16'h0040);
    chk("t2 no valid", instr_valid[0], 1'b0);
    cycle();
    chk("t2 still no valid", instr_valid[0], 1'b0);

    // 3: redirect while fetch of 0042 outstanding (late ack), two redirects
    run_until_ack(16'h0040, 10);
    lat = 3;
    cycle();
    chk("t3 pending addr", imem_addr[0], 16'h0042);
    redirect_valid = 1; redirect_target = 16'h0080;
    cycle();
    chk("t3 drain addr a", imem_addr[0], 16'h0042);
    redirect_target = 16'h0100;
    cycle();
    redirect_valid = 0;
    chk("t3 drain addr b", imem_addr[0], 16'h0042);
    cycle();
    chk("t3 drain addr c", imem_addr[0], 16'h0042);
    chk("t3 late ack", imem_ack[0], 1'b1);
    lat = 1;
    cycle();
    chk("t3 target addr", imem_addr[0], 16'h0100);
    chk("t3 req", imem_req[0], 1'b1);
    chk("t3 no valid", instr_valid[0], 1'b0);

    // 4: stall hold, release, redirect during stall
    run_until_ack(16'h0100, 10);
    cycle();
    run_until_ack(16'h0102, 10);
    stall = 1;
    cycle();
    chk("t4 req low", imem_req[0], 1'b0);
    chk("t4 held pc", instr_pc[0], 16'h0102);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t4 hold req", imem_req[0], 1'b0);
      chk("t4 hold valid", instr_valid[0], 1'b1);
      chk("t4 hold instr", instr[0], 16'hA102);
    end
    stall = 0;
    cycle();
    chk("t4 resume addr", imem_addr[0], 16'h0104);
    chk("t4 resume valid", instr_valid[0], 1'b0);
    run_until_ack(16'h0104, 10);
    stall = 1;
    cycle();
    cycle();
    redirect_valid = 1; redirect_target = 16'h0200;
    cycle();
    redirect_valid = 0; stall = 0;
    chk("t4 redirect valid", instr_valid[0], 1'b0);
    chk("t4 redirect addr", imem_addr[0], 16'h0200);

    // 5: misaligned target
    run_until_ack(16'h0200, 10);
    redirect_valid = 1; redirect_target = 16'h0031;
    cycle();
    redirect_valid = 0;
    chk("t5 misalign pulse", misalign_err[0], 1'b1);
    chk("t5 aligned addr", imem_addr[0], 16'h0030);
    cycle();
    chk("t5 misalign drop", misalign_err[0], 1'b0);
    run_until_ack(16'h0030, 10);
    cycle();
    chk("t5 instr_pc", instr_pc[0], 16'h0030);
    chk("t5 pc_plus_two", pc_plus_two[0], 16'h0032);

    // 6: async reset with request pending; ack during reset/BOOT ignored
    chk("t6 pending", imem_req[0], 1'b1);
    #2 rst_n = 0;
    #1;
    chk("t6 async req d0", imem_req[0], 1'b0);
    chk("t6 async req d1", imem_req[1], 1'b0);
    chk("t6 async addr", imem_addr[0], 16'h0000);
    chk("t6 async valid", instr_valid[0], 1'b0);
    for (int d = 0; d < 2; d++) model_reset(d);
    force_ack = 1;
    mem_update();
    cycle();
    #2 rst_n = 1;
    force_ack = 0;
    cycle();
    chk("t6 boot addr d0", imem_addr[0], 16'h0000);
    chk("t6 boot addr d1", imem_addr[1], 16'hFFFE);
    chk("t6 boot valid", instr_valid[0], 1'b0);
    run_until_ack(16'h0000, 10);
    cycle();
    chk("t6 refetch pc", instr_pc[0], 16'h0000);
    chk("t6 refetch instr", instr[0], 16'hA000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
